// File: rtl/gray_pkg.sv
// Shared constants and reference helpers for the binary/Gray codec.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gray_codec_if.sv
// Request/response signal bundle for gray_codec; the slave side is the codec.
interface gray_codec_if #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_single_step;

  modport master (
    output in_valid, mode, in_data,
    input  out_valid, out_data, out_single_step
  );

  modport slave (
    input  in_valid, mode, in_data,
    output out_valid, out_data, out_single_step
  );
endinterface

// File: rtl/gray_xor_slice.sv
// One bit position of the codec: Gray bit from the neighbour XOR, binary bit
// from the XOR of this bit and everything above it (no ripple between slices).
module gray_xor_slice #(
  parameter int WIDTH = 4,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] data,
  output logic             gray_bit,
  output logic             bin_bit
);
  logic [WIDTH-1:0] hi;

  assign hi      = data >> IDX;
  assign bin_bit = ^hi;

  if (IDX == WIDTH - 1) begin : g_msb
    assign gray_bit = data[IDX];
  end else begin : g_lsb
    assign gray_bit = data[IDX+1] ^ data[IDX];
  end
endmodule

// File: rtl/gray_codec.sv
// Registered binary<->Gray converter with a single-bit-step flag on the
// Gray-domain stream. One cycle latency, one conversion per cycle.
module gray_codec
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  gray_codec_if.slave bus
);
  logic [WIDTH-1:0] gray_c;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] cur_gray;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic [31:0]      diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    gray_xor_slice #(.WIDTH(WIDTH), .IDX(i)) u_slice (
      .data     (bus.in_data),
      .gray_bit (gray_c[i]),
      .bin_bit  (bin_c[i])
    );
  end

  // Step check always runs on the Gray-domain value, whichever way we convert.
  assign cur_gray = (bus.mode == MODE_G2B) ? bus.in_data : gray_c;
  assign conv     = (bus.mode == MODE_G2B) ? bin_c : gray_c;
  assign diff     = 32'(cur_gray ^ prev_gray);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid       <= 1'b0;
      bus.out_data        <= '0;
      bus.out_single_step <= 1'b0;
      prev_gray           <= '0;
      have_prev           <= 1'b0;
    end else if (bus.in_valid) begin
      bus.out_valid       <= 1'b1;
      bus.out_data        <= conv;
      bus.out_single_step <= have_prev && (popcount(diff) == 1);
      prev_gray           <= cur_gray;
      have_prev           <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gray_codec.sv
// Directed-vector bench for gray_codec (WIDTH=4).
module tb_gray_codec;
  localparam int W = 4;

  typedef struct {
    logic         vld;
    logic         mode;
    logic [W-1:0] data;
    logic         exp_vld;
    logic [W-1:0] exp_data;
    logic         exp_step;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  logic [W-1:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_codec_if #(.WIDTH(W)) bus ();

  gray_codec #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] d, input logic s);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, " out_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, " out_single_step"}, 32'(bus.out_single_step), 32'(s));
  endtask

  task automatic add(input logic v, input logic m, input logic [W-1:0] d,
                     input logic ev, input logic [W-1:0] ed, input logic es);
    vec_t t;
    t.vld = v; t.mode = m; t.data = d;
    t.exp_vld = ev; t.exp_data = ed; t.exp_step = es;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic m, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.mode     = m;
    bus.in_data  = d;
  endtask

  initial begin
    // B2G over all 16 codes; first after reset has no history.
    for (int i = 0; i < 16; i++) add(1, 0, W'(i), 1, gseq[i], i != 0);
    // Wrap: F (Gray 8, same as previous) then 0 (Gray 0, one step).
    add(1, 0, 4'hF, 1, 4'h8, 0);
    add(1, 0, 4'h0, 1, 4'h0, 1);
    // 0 then 2: Gray 0000 -> 0011 is two bits.
    add(1, 0, 4'h0, 1, 4'h0, 0);
    add(1, 0, 4'h2, 1, 4'h3, 0);
    // G2B spot check: 1110 -> 1011; Gray 0011 -> 1110 is three bits.
    add(1, 1, 4'hE, 1, 4'hB, 0);
    // Round trip: Gray codes back to their binary index.
    for (int i = 0; i < 16; i++) add(1, 1, gseq[i], 1, W'(i), i != 0);
    // Bubbles: 7 (Gray 4, vs 8 two bits), idle, idle (hold), 8 (Gray C, one step).
    add(1, 0, 4'h7, 1, 4'h4, 0);
    add(0, 0, 4'hA, 0, 4'h4, 0);
    add(0, 1, 4'h5, 0, 4'h4, 0);
    add(1, 0, 4'h8, 1, 4'hC, 1);
    // Mode change: G2B of C -> 8, Gray-domain value C repeats.
    add(1, 1, 4'hC, 1, 4'h8, 0);

    // Reset dominates in_valid.
    drive(1, 0, 4'hF);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_out($sformatf("reset%0d", c), 0, 4'h0, 0);
    end
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].vld, vecs[k].mode, vecs[k].data);
      @(negedge clk);
      chk_out($sformatf("vec%0d", k), vecs[k].exp_vld, vecs[k].exp_data, vecs[k].exp_step);
    end

    // Mid-stream reset: 1, 2, then reset while 3 is presented.
    drive(1, 0, 4'h1);
    @(negedge clk);
    chk_out("mid1", 1, 4'h1, 0);
    drive(1, 0, 4'h2);
    @(negedge clk);
    chk_out("mid2", 1, 4'h3, 1);
    drive(1, 0, 4'h3);
    rst_n = 1'b0;
    @(negedge clk);
    chk_out("mid_rst", 0, 4'h0, 0);
    rst_n = 1'b1;
    drive(1, 0, 4'h3);
    @(negedge clk);
    chk_out("mid_after", 1, 4'h2, 0);
    drive(0, 0, 4'h0);
    @(negedge clk);
    chk_out("mid_idle", 0, 4'h2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gray_codec.md
Name: gray_codec

Overview:
- Registered binary/Gray code converter.
- Bit-sliced XOR datapath: g[i] = b[i+1] XOR b[i], with the MSB passed through unchanged.
- Runtime mode select between binary-to-Gray and Gray-to-binary.
- Also flags whether consecutive Gray-domain values differ in exactly one bit.
- Sits between position/counter logic and clock-domain or encoder interfaces needing Gray sequences.

Parameters:
- WIDTH, 4, data width in bits (legal range 2..32); bit WIDTH-1 is MSB.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  in_data/mode qualified this cycle
- mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
- in_data  input  WIDTH  value to convert
- out_valid  output  1  out_data/out_single_step qualified
- out_data  output  WIDTH  converted value
- out_single_step  output  1  current Gray-domain value differs from the previous valid Gray-domain value in exactly one bit

Behaviour:
- Reset: synchronous, active-low, on rising clk while rst_n=0.
  - Reset values: out_valid=0, out_data=0, out_single_step=0.
  - Internal prev_gray=0 and have_prev=0.
  - Reset dominates in_valid in the same cycle.
- Binary-to-Gray (mode=0):
  - gray[WIDTH-1] = in_data[WIDTH-1].
  - gray[i] = in_data[i+1] ^ in_data[i] for i < WIDTH-1.
  - out_data = gray.
- Gray-to-binary (mode=1):
  - bin[WIDTH-1] = in_data[WIDTH-1].
  - bin[i] = bin[i+1] ^ in_data[i], an XOR prefix from the MSB down.
  - out_data = bin.
- Latency: exactly 1 cycle.
  - An in_valid=1 sample at edge N appears on out_valid/out_data after edge N.
  - Full throughput of one conversion per cycle; no backpressure.
- Idle cycles: when in_valid=0, out_valid=0 next cycle.
  - out_data and out_single_step hold their last values; downstream must ignore them.
- Gray-domain value per accepted input:
  - in_data itself when mode=1.
  - The computed gray when mode=0.
- Step check, per accepted input:
  - out_single_step = have_prev & (popcount(cur_gray ^ prev_gray) == 1).
  - Then prev_gray <= cur_gray and have_prev <= 1.
- First accepted input after reset: out_single_step=0.
- Identical consecutive values: popcount 0, so out_single_step=0.
- Wrap-around: binary max to 0 maps Gray 100..0 to 000..0, a single step, so out_single_step=1.
- Mode change between transactions is legal. The step check always compares Gray-domain values regardless of mode.
- Purely combinational path from inputs to register D only; all outputs are registered.
- No X propagation: in_data with in_valid=0 does not affect state.

Decomposition:
- Shared package gray_pkg holds:
  - GRAY_WIDTH_DEFAULT=4.
  - localparam mode encodings MODE_B2G=1'b0 and MODE_G2B=1'b1.
  - Pure functions bin2gray(), gray2bin(), popcount().
- One sub-module, gray_xor_slice (per-bit XOR stage, generate-replicated), is natural.
- Top gray_codec holds the registers, mode mux and step checker.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, in_data=4'hF -> out_valid=0, out_data=0, out_single_step=0 throughout. First accepted input after release gives out_single_step=0.
- B2G exhaustive: mode=0, in_data 0..15, one per cycle -> out_data one cycle later follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
  - out_single_step=0 on the first value, 1 on every subsequent one.
- G2B spot check: mode=1, in_data=4'b1110 -> out_data=4'b1011.
  - Round trip of all 16 codes through B2G then G2B returns the original value.
- Wrap and non-step:
  - mode=0, in_data 4'hF then 4'h0 -> second out_data=0, out_single_step=1.
  - mode=0, in_data 4'h0 then 4'h2 (Gray 0000 to 0011) -> out_single_step=0.
- Bubbles: in_valid pattern 1,0,0,1 with in_data 7 then 8 -> out_valid pattern 1,0,0,1.
  - Outputs: out_data 4'h4 then 4'hC, out_single_step=1 on the second.
- Mid-stream reset: stream 1,2,3, assert rst_n=0 one cycle after the second input -> out_valid=0 next edge.
  - After release, in_data=3 gives out_single_step=0 (history cleared).
